ldm_stm_sequencer: RTL and testbench

- Multi-cycle controller that sequences ARMv4 block data transfers (LDM/STM) through the register bank and the data memory port.
- Walks a 16-bit register list in ascending register order and issues one memory transfer per set bit.
- Drives register-bank read port 2 (STM source), the write port (LDM destination and base writeback), and a PC load path for R15.
- Sits beside the main decoder; while busy it owns the register-bank write port.

---
 rtl/ldm_stm_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM block-transfer controller.
// Walks the register list lowest-bit first, issuing one memory transfer per
// set bit at ascending word addresses, then optionally writes back the base.
// Optional feature macro: LDM_STM_BASE_WB_EN (base register writeback).
// Without it the WB state is never entered and wback/base_reg are ignored.
module ldm_stm_sequencer #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load,
  input  logic          pre,
  input  logic          up,
  input  logic          wback,
  input  logic [RW-1:0] base_reg,
  input  logic [15:0]   reg_list,
  input  logic [DW-1:0] base_val,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [RW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          rf_we,
  output logic [RW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          pc_we,
  output logic [DW-1:0] pc_wd
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

  state_t        state, nstate;
  logic          l_load;
  logic [15:0]   l_list;      // registers still to transfer
  logic [DW-1:0] l_addr;      // address of the current transfer

  logic [4:0]    n;
  logic [DW-1:0] n4;
  logic [DW-1:0] start_addr;
  logic [RW-1:0] cur;
  logic          last;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Transfer count and block start address (addresses always ascend).
  always_comb begin
    n  = popcount16(reg_list);
    n4 = {{(DW-7){1'b0}}, n, 2'b00};
    case ({pre, up})
      2'b01:   start_addr = base_val;                        // IA
      2'b11:   start_addr = base_val + DW'(4);               // IB
      2'b00:   start_addr = base_val - n4 + DW'(4);          // DA
      default: start_addr = base_val - n4;                   // DB
    endcase
  end

  // Current register = lowest set bit of the remaining list.
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--)
      if (l_list[i]) cur = RW'(i);
    last = ((l_list & (l_list - 16'd1)) == 16'd0);
  end

`ifdef LDM_STM_BASE_WB_EN
  logic          l_wb;
  logic [RW-1:0] l_base_reg;
  logic [DW-1:0] l_fbase;
  logic          wb_ok;
  logic [DW-1:0] fbase;

  // Writeback is skipped for R15 and when an LDM reloads the base itself.
  always_comb begin
    fbase = up ? base_val + n4 : base_val - n4;
    wb_ok = wback && (base_reg != {RW{1'b1}}) && !(load && reg_list[base_reg]);
  end

  // Latch the writeback target and final base with the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_wb       <= 1'b0;
      l_base_reg <= '0;
      l_fbase    <= '0;
    end else if (state == S_IDLE && start) begin
      l_wb       <= wb_ok;
      l_base_reg <= base_reg;
      l_fbase    <= fbase;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wback, base_reg};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Request latch and per-ack list/address advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_load <= 1'b0;
      l_list <= '0;
      l_addr <= '0;
    end else if (state == S_IDLE && start) begin
      l_load <= load;
      l_list <= reg_list;
      l_addr <= start_addr;
    end else if (state == S_XFER && mem_ack) begin
      l_list <= l_list & (l_list - 16'd1);
      l_addr <= l_addr + DW'(4);
    end
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (start) nstate = (n == 5'd0) ? S_DONE : S_XFER;
      S_XFER: if (mem_ack && last) begin
`ifdef LDM_STM_BASE_WB_EN
        nstate = l_wb ? S_WB : S_DONE;
`else
        nstate = S_DONE;
`endif
      end
      S_WB:    nstate = S_DONE;
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs decoded from state; forced quiet while reset is asserted so a
  // mid-transfer reset cannot leak a register or PC write.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_ra     = '0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    if (!rst) begin
      case (state)
        S_XFER: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_we   = !l_load;
          mem_addr = l_addr;
          if (!l_load) begin
            rf_ra     = cur;
            mem_wdata = rf_rd;
          end else if (mem_ack) begin
            if (cur == {RW{1'b1}}) begin
              pc_we = 1'b1;
              pc_wd = {mem_rdata[DW-1:2], 2'b00};
            end else begin
              rf_we = 1'b1;
              rf_wa = cur;
              rf_wd = mem_rdata;
            end
          end
        end
`ifdef LDM_STM_BASE_WB_EN
        S_WB: begin
          busy  = 1'b1;
          rf_we = 1'b1;
          rf_wa = l_base_reg;
          rf_wd = l_fbase;
        end
`endif
        S_DONE:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: STM/LDM addressing modes, wait
// states, R15 load, base writeback suppression, empty list, mid-run reset.
module tb_ldm_stm_sequencer;
  logic        clk = 0;
  logic        rst, start, load, pre, up, wback, mem_ack;
  logic [3:0]  base_reg;
  logic [15:0] reg_list;
  logic [31:0] base_val, mem_rdata;
  logic        busy, done, mem_req, mem_we, rf_we, pc_we;
  logic [31:0] mem_addr, mem_wdata, rf_rd, rf_wd, pc_wd;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rfm [16];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;
  assign rf_rd = rfm[rf_ra];

  ldm_stm_sequencer #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .pre(pre), .up(up),
    .wback(wback), .base_reg(base_reg), .reg_list(reg_list), .base_val(base_val),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd)
  );

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge clk); #1;
  endtask

  // Issue a request in IDLE; returns in the first XFER (or DONE) cycle.
  task automatic issue(input logic l, input logic p, input logic u, input logic w,
                       input logic [3:0] rn, input logic [15:0] lst, input logic [31:0] b);
    start = 1; load = l; pre = p; up = u; wback = w;
    base_reg = rn; reg_list = lst; base_val = b;
    cyc();
    start = 0;
  endtask

  task automatic test_reset;
    rst = 1; start = 0; load = 0; pre = 0; up = 0; wback = 0; mem_ack = 0;
    base_reg = 0; reg_list = 0; base_val = 0; mem_rdata = 0;
    cyc(); cyc(); #1;
    checks++; if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b0) begin fails++; $display("FAIL reset_ctl got %b exp 000000", {busy, done, mem_req, mem_we, rf_we, pc_we}); end
    checks++; if ({mem_addr, mem_wdata, rf_wd, pc_wd} !== 128'b0) begin fails++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, rf_wd, pc_wd}); end
    checks++; if ({rf_ra, rf_wa} !== 8'b0) begin fails++; $display("FAIL reset_idx got %h exp 00", {rf_ra, rf_wa}); end
    rst = 0;
    cyc();
  endtask

  task automatic test_stmia;
    for (int i = 0; i < 16; i++) rfm[i] = 32'hA0 + i;
    issue(0, 0, 1, 0, 4'd0, 16'h000F, 32'h100);
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({busy, mem_req, mem_we, rf_we, pc_we, done} !== 6'b111000) begin fails++; $display("FAIL stmia_ctl[%0d] got %b exp 111000", i, {busy, mem_req, mem_we, rf_we, pc_we, done}); end
      checks++; if (mem_addr !== 32'h100 + 4*i) begin fails++; $display("FAIL stmia_addr[%0d] got %h exp %h", i, mem_addr, 32'h100 + 4*i); end
      checks++; if (mem_wdata !== 32'hA0 + i) begin fails++; $display("FAIL stmia_wdata[%0d] got %h exp %h", i, mem_wdata, 32'hA0 + i); end
      cyc();
    end
    mem_ack = 0; #1;
    checks++; if ({done, busy, mem_req, rf_we} !== 4'b1000) begin fails++; $display("FAIL stmia_done got %b exp 1000", {done, busy, mem_req, rf_we}); end
    cyc(); #1;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL stmia_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_ldmdb_pc;
    logic [31:0] rd [3];
    logic [3:0]  wa [3];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h1003;
    wa[0] = 4'd1;   wa[1] = 4'd2;   wa[2] = 4'd15;
    issue(1, 1, 0, 1, 4'd4, 16'h8006, 32'h200);
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = rd[i]; #1;
      checks++; if ({mem_req, mem_we} !== 2'b10) begin fails++; $display("FAIL ldmdb_req[%0d] got %b exp 10", i, {mem_req, mem_we}); end
      checks++; if (mem_addr !== 32'h1F4 + 4*i) begin fails++; $display("FAIL ldmdb_addr[%0d] got %h exp %h", i, mem_addr, 32'h1F4 + 4*i); end
      if (i < 2) begin
        checks++; if ({rf_we, pc_we, rf_wa, rf_wd} !== {2'b10, wa[i], rd[i]}) begin fails++; $display("FAIL ldmdb_rf[%0d] got %b/%b/%h/%h exp 1/0/%h/%h", i, rf_we, pc_we, rf_wa, rf_wd, wa[i], rd[i]); end
      end else begin
        checks++; if ({rf_we, pc_we, pc_wd} !== {2'b01, 32'h1000}) begin fails++; $display("FAIL ldmdb_pc got %b/%b/%h exp 0/1/00001000", rf_we, pc_we, pc_wd); end
      end
      cyc();
    end
    mem_ack = 0; mem_rdata = 0; #1;
`ifdef LDM_STM_BASE_WB_EN
    checks++; if ({busy, mem_req, rf_we, rf_wa, rf_wd, done} !== {3'b101, 4'd4, 32'h1F4, 1'b0}) begin fails++; $display("FAIL ldmdb_wb got %b%b%b/%h/%h/%b exp 101/4/000001f4/0", busy, mem_req, rf_we, rf_wa, rf_wd, done); end
    cyc(); #1;
`endif
    checks++; if ({done, busy, rf_we, pc_we} !== 4'b1000) begin fails++; $display("FAIL ldmdb_done got %b exp 1000", {done, busy, rf_we, pc_we}); end
    cyc();
  endtask

  task automatic test_ldmia_base_in_list;
    issue(1, 0, 1, 1, 4'd2, 16'h0006, 32'h300);
    mem_ack = 1; mem_rdata = 32'h5555; #1;
    checks++; if ({mem_addr, rf_we, rf_wa, rf_wd} !== {32'h300, 1'b1, 4'd1, 32'h5555}) begin fails++; $display("FAIL ldmia_r1 got %h/%b/%h/%h exp 00000300/1/1/00005555", mem_addr, rf_we, rf_wa, rf_wd); end
    cyc();
    mem_rdata = 32'hBEEF; #1;
    checks++; if ({mem_addr, rf_we, rf_wa, rf_wd} !== {32'h304, 1'b1, 4'd2, 32'hBEEF}) begin fails++; $display("FAIL ldmia_r2 got %h/%b/%h/%h exp 00000304/1/2/0000beef", mem_addr, rf_we, rf_wa, rf_wd); end
    cyc();
    mem_ack = 0; mem_rdata = 0; #1;
    checks++; if ({done, busy, rf_we} !== 3'b100) begin fails++; $display("FAIL ldmia_no_wb got %b exp 100", {done, busy, rf_we}); end
    cyc();
  endtask

  task automatic test_stmib_wait;
    issue(0, 1, 1, 0, 4'd0, 16'h0001, 32'h100);
    mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1;
      // A start while busy must be ignored.
      if (i == 1) begin start = 1; reg_list = 16'hFFFF; end
      #1;
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h104, 32'hA0}) begin fails++; $display("FAIL stmib_hold[%0d] got %b%b/%h/%h exp 11/00000104/000000a0", i, mem_req, mem_we, mem_addr, mem_wdata); end
      cyc();
      start = 0; reg_list = 16'h0001;
    end
    mem_ack = 0; #1;
    checks++; if ({done, mem_req, busy} !== 3'b100) begin fails++; $display("FAIL stmib_done got %b exp 100", {done, mem_req, busy}); end
    cyc(); #1;
    checks++; if ({done, mem_req, busy} !== 3'b000) begin fails++; $display("FAIL stmib_idle got %b exp 000", {done, mem_req, busy}); end
  endtask

  task automatic test_empty_list;
    issue(1, 0, 1, 1, 4'd3, 16'h0000, 32'h700);
    #1;
    checks++; if ({done, busy, mem_req, rf_we, pc_we} !== 5'b10000) begin fails++; $display("FAIL empty_done got %b exp 10000", {done, busy, mem_req, rf_we, pc_we}); end
    cyc(); #1;
    checks++; if ({done, busy, mem_req, rf_we, pc_we} !== 5'b00000) begin fails++; $display("FAIL empty_after got %b exp 00000", {done, busy, mem_req, rf_we, pc_we}); end
  endtask

  task automatic test_reset_mid;
    issue(1, 0, 1, 0, 4'd0, 16'h00F0, 32'h400);
    mem_ack = 1; mem_rdata = 32'h44; #1;
    checks++; if ({rf_we, rf_wa, mem_addr} !== {1'b1, 4'd4, 32'h400}) begin fails++; $display("FAIL rstmid_first got %b/%h/%h exp 1/4/00000400", rf_we, rf_wa, mem_addr); end
    cyc();
    rst = 1; mem_rdata = 32'h55; #1;
    checks++; if ({rf_we, pc_we, mem_req, busy} !== 4'b0000) begin fails++; $display("FAIL rstmid_rstcyc got %b exp 0000", {rf_we, pc_we, mem_req, busy}); end
    cyc();
    rst = 0; #1;
    checks++; if ({busy, done, mem_req, rf_we, pc_we, mem_addr, rf_wa} !== 41'b0) begin fails++; $display("FAIL rstmid_idle got %b%b%b%b%b/%h/%h exp 00000/0/0", busy, done, mem_req, rf_we, pc_we, mem_addr, rf_wa); end
    cyc(); #1;
    checks++; if ({busy, rf_we} !== 2'b00) begin fails++; $display("FAIL rstmid_quiet got %b exp 00", {busy, rf_we}); end
    mem_ack = 0; mem_rdata = 0;
    issue(0, 0, 1, 0, 4'd0, 16'h0001, 32'h500);
    mem_ack = 1; #1;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h500, 32'hA0}) begin fails++; $display("FAIL rstmid_restart got %b%b/%h/%h exp 11/00000500/000000a0", mem_req, mem_we, mem_addr, mem_wdata); end
    cyc();
    mem_ack = 0; #1;
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL rstmid_done got %b exp 1", done); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_stmia();
    test_ldmdb_pc();
    test_ldmia_base_in_list();
    test_stmib_wait();
    test_empty_list();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
